// File: rtl/pkt_tx_serializer.sv
// pkt_tx_serializer
//   Pops one WIDTH-bit packet word from an upstream first-word-fall-through
//   FIFO and sends it as ceil(WIDTH/TDATA_W) AXI-Stream beats. Byte 0 of the
//   word goes out first, on tdata[7:0]. The last beat carries a partial tkeep
//   and tlast. When the FIFO still holds a word as the last beat is accepted,
//   that word is popped in the same cycle, so packets follow each other with
//   no idle beat in between.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   fifo_empty     : upstream FIFO empty flag
//   fifo_read_data : upstream FIFO head word (valid while fifo_empty = 0)
//   fifo_pop       : one-cycle pop strobe to the upstream FIFO
//   m_axis_tdata   : stream data
//   m_axis_tkeep   : stream byte qualifiers
//   m_axis_tvalid  : stream valid
//   m_axis_tready  : stream ready from downstream
//   m_axis_tlast   : final beat of a packet
//   tx_busy        : high while a word is held or being sent
//   tx_pkt_count   : completed-packet counter (16 bit, wraps)
//
// Configuration
//   PKT_TX_STATS_EN : when defined, tx_pkt_count counts completed packets.
//                     When undefined, tx_pkt_count is tied to zero and no
//                     counter is built.

module pkt_tx_serializer #(
  parameter int WIDTH   = 592,
  parameter int TDATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   fifo_pop,
  output logic [TDATA_W-1:0]     m_axis_tdata,
  output logic [TDATA_W/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   tx_busy,
  output logic [15:0]            tx_pkt_count
);

  localparam int KEEP_W    = TDATA_W / 8;
  localparam int NBEATS    = (WIDTH + TDATA_W - 1) / TDATA_W;
  localparam int LASTBYTES = (WIDTH / 8) - (NBEATS - 1) * KEEP_W;
  localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PAD_W     = NBEATS * TDATA_W;

  // Low LASTBYTES bits set: the valid bytes of the final beat.
  localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LASTBYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_next;
  logic [WIDTH-1:0]  held;
  logic              load;
  logic              last_beat;
  logic              handshake;

  // Zero-extend the held word to a whole number of beats so the bits past
  // WIDTH on the final beat come out as 0.
  logic [PAD_W-1:0]   held_padded;
  logic [TDATA_W-1:0] beat_word [NBEATS];

  always_comb begin
    held_padded             = '0;
    held_padded[WIDTH-1:0]  = held;
  end

  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
      assign beat_word[gi] = held_padded[gi*TDATA_W +: TDATA_W];
    end
  endgenerate

  assign last_beat = (beat == BEAT_W'(NBEATS - 1));
  assign handshake = m_axis_tvalid & m_axis_tready;

  // Next-state and outputs. tvalid/tdata/tkeep/tlast depend only on
  // registered state, so they hold steady under backpressure and drop to
  // zero as soon as reset forces IDLE.
  always_comb begin
    state_next    = state;
    beat_next     = beat;
    load          = 1'b0;
    fifo_pop      = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    tx_busy       = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          beat_next  = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        tx_busy       = 1'b1;
        m_axis_tdata  = beat_word[beat];
        m_axis_tkeep  = last_beat ? LAST_KEEP : {KEEP_W{1'b1}};
        m_axis_tlast  = last_beat;
        if (m_axis_tready) begin
          if (last_beat) begin
            beat_next = '0;
            // Chain straight into the next packet when a word is waiting.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    fifo_pop = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      held  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      if (load) begin
        held <= fifo_read_data;
      end
    end
  end

`ifdef PKT_TX_STATS_EN
  logic [15:0] pkt_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= 16'd0;
    end else if (handshake && last_beat) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  assign tx_pkt_count = pkt_count;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign tx_pkt_count     = 16'd0;
`endif

endmodule

// File: tb/tb_pkt_tx_serializer.sv
// tb_pkt_tx_serializer
//   Self-checking bench for pkt_tx_serializer with default parameters
//   (592-bit words, 64-bit stream: 10 beats, 2 bytes on the last beat).
//   A queue models the upstream FIFO; each pop pushes the expected beats of
//   the popped word onto a scoreboard, which is compared on every accepted
//   beat. A scenario table drives multi-word runs with optional stalls;
//   hand-written sequences cover reset, idle, the ramp word and a
//   mid-packet reset.

module tb_pkt_tx_serializer;

  localparam int W   = 592;
  localparam int TW  = 64;
  localparam int NB  = 10;
  localparam int NBY = 74;

  logic           clk;
  logic           rst_n;
  logic           fifo_empty;
  logic [W-1:0]   fifo_read_data;
  logic           fifo_pop;
  logic [TW-1:0]  m_axis_tdata;
  logic [7:0]     m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           tx_busy;
  logic [15:0]    tx_pkt_count;

  pkt_tx_serializer #(.WIDTH(W), .TDATA_W(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .tx_busy        (tx_busy),
    .tx_pkt_count   (tx_pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int nwords;
    int stall_beat;
    int stall_len;
    int exp_valid;
    int exp_pops;
  } scen_t;

  logic [W-1:0] fifo_q[$];
  beat_t        sb[$];

  int checks;
  int passed;
  int cyc;

  // per-run metrics
  int valid_cycles;
  int first_valid;
  int last_valid;
  int pop_cycles[$];
  int hs_in_pkt;

  // capture of the beats of the most recent packet
  logic [63:0] cap_data [NB];
  logic [7:0]  cap_keep [NB];
  logic        cap_last [NB];

  // previous-cycle state for latency / stability checks
  logic        prev_pop;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  // stall plan
  int stall_beat;
  int stall_len;
  int stall_left;
  bit stall_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_fifo();
    fifo_empty     = (fifo_q.size() == 0);
    fifo_read_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  function automatic void push_expected(input logic [W-1:0] w);
    for (int k = 0; k < NB; k++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int b = 0; b < 8; b++) begin
        int idx;
        idx = k * 8 + b;
        if (idx < NBY) begin
          e.data[b*8 +: 8] = w[idx*8 +: 8];
          e.keep[b]        = 1'b1;
        end
      end
      e.last = (k == NB - 1);
      sb.push_back(e);
    end
  endfunction

  function automatic logic [W-1:0] make_word(input bit ramp);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < NBY; i++)
      w[i*8 +: 8] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
    return w;
  endfunction

  // One clock cycle: observe and check at the falling edge, then advance
  // the FIFO model and the tready plan just after the rising edge.
  task automatic step();
    bit pop_now;
    pop_now = 1'b0;
    @(negedge clk);
    if (rst_n) begin
      if (fifo_pop) check("pop_while_empty", 64'(fifo_empty), 64'd0);
      if (prev_pop) check("valid_after_pop", 64'(m_axis_tvalid), 64'd1);
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data",  m_axis_tdata, prev_data);
        check("stall_keep",  64'(m_axis_tkeep), 64'(prev_keep));
        check("stall_last",  64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", m_axis_tdata, e.data);
          check("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
          check("beat_last", 64'(m_axis_tlast), 64'(e.last));
        end
        if (hs_in_pkt < NB) begin
          cap_data[hs_in_pkt] = m_axis_tdata;
          cap_keep[hs_in_pkt] = m_axis_tkeep;
          cap_last[hs_in_pkt] = m_axis_tlast;
        end
        hs_in_pkt = m_axis_tlast ? 0 : hs_in_pkt + 1;
      end
      if (fifo_pop && fifo_q.size() > 0) begin
        push_expected(fifo_q[0]);
        pop_cycles.push_back(cyc);
        pop_now = 1'b1;
      end
      prev_pop   = fifo_pop;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
    end else begin
      prev_pop   = 1'b0;
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now) begin
      void'(fifo_q.pop_front());
      drive_fifo();
    end
    if (stall_left > 0) begin
      m_axis_tready = 1'b0;
      stall_left--;
    end else if (!stall_done && m_axis_tvalid && hs_in_pkt == stall_beat) begin
      m_axis_tready = 1'b0;
      stall_left    = stall_len - 1;
      stall_done    = 1'b1;
    end else begin
      m_axis_tready = 1'b1;
    end
  endtask

  task automatic clear_metrics();
    valid_cycles = 0;
    first_valid  = -1;
    last_valid   = -1;
    pop_cycles.delete();
  endtask

  task automatic run_words(input int nwords, input int sbeat, input int slen, input bit ramp);
    bit done;
    clear_metrics();
    stall_beat = sbeat;
    stall_len  = slen;
    stall_left = 0;
    stall_done = (slen == 0);
    for (int i = 0; i < nwords; i++) fifo_q.push_back(make_word(ramp));
    drive_fifo();
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (fifo_q.size() == 0 && sb.size() == 0 && !m_axis_tvalid) done = 1'b1;
    end
    check("run_completes", 64'(done), 64'd1);
  endtask

  scen_t scen [5];
  int    pkts_since_reset;
  int    bad;

  initial begin
    checks = 0; passed = 0; cyc = 0;
    hs_in_pkt = 0; prev_pop = 0; prev_stall = 0;
    prev_data = '0; prev_keep = '0; prev_last = 0;
    stall_beat = 0; stall_len = 0; stall_left = 0; stall_done = 1;
    pkts_since_reset = 0;
    clear_metrics();

    scen[0] = '{nwords: 1, stall_beat: 0, stall_len: 0, exp_valid: 10, exp_pops: 1};
    scen[1] = '{nwords: 1, stall_beat: 3, stall_len: 5, exp_valid: 15, exp_pops: 1};
    scen[2] = '{nwords: 3, stall_beat: 0, stall_len: 0, exp_valid: 30, exp_pops: 3};
    scen[3] = '{nwords: 2, stall_beat: 9, stall_len: 2, exp_valid: 22, exp_pops: 2};
    scen[4] = '{nwords: 2, stall_beat: 0, stall_len: 3, exp_valid: 23, exp_pops: 2};

    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    drive_fifo();

    // Reset state
    #3;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_pop",    64'(fifo_pop),      64'd0);
    check("rst_tdata",  m_axis_tdata,       64'd0);
    check("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
    check("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_busy",   64'(tx_busy),       64'd0);
    check("rst_count",  64'(tx_pkt_count),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty idle: nothing moves for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fifo_pop !== 1'b0 || m_axis_tvalid !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    check("idle_quiet_cycles", 64'(bad), 64'd0);

    // Ramp word: bytes 0..73
    run_words(1, 0, 0, 1'b1);
    pkts_since_reset += 1;
    check("ramp_beat0_data", cap_data[0], 64'h0706050403020100);
    check("ramp_beat8_keep", 64'(cap_keep[8]), 64'hff);
    check("ramp_beat9_data", cap_data[9], 64'h0000000000004948);
    check("ramp_beat9_keep", 64'(cap_keep[9]), 64'h03);
    check("ramp_beat9_last", 64'(cap_last[9]), 64'd1);
    check("ramp_first_valid", 64'(first_valid - pop_cycles[0]), 64'd1);
    check("ramp_valid_cycles", 64'(valid_cycles), 64'd10);

    // Scenario table
    for (int s = 0; s < 5; s++) begin
      run_words(scen[s].nwords, scen[s].stall_beat, scen[s].stall_len, 1'b0);
      pkts_since_reset += scen[s].nwords;
      $display("scenario %0d: words=%0d stall@%0d x%0d valid=%0d pops=%0d",
               s, scen[s].nwords, scen[s].stall_beat, scen[s].stall_len,
               valid_cycles, pop_cycles.size());
      check("scen_valid_cycles", 64'(valid_cycles), 64'(scen[s].exp_valid));
      check("scen_no_gaps", 64'(last_valid - first_valid + 1), 64'(scen[s].exp_valid));
      check("scen_pops", 64'(pop_cycles.size()), 64'(scen[s].exp_pops));
      if (pop_cycles.size() > 0)
        check("scen_first_latency", 64'(first_valid - pop_cycles[0]), 64'd1);
      if (scen[s].stall_len == 0)
        for (int p = 1; p < pop_cycles.size(); p++)
          check("scen_pop_spacing", 64'(pop_cycles[p] - pop_cycles[0]), 64'(p * NB));
    end

`ifdef PKT_TX_STATS_EN
    check("pkt_count", 64'(tx_pkt_count), 64'(pkts_since_reset % 65536));
`else
    check("pkt_count", 64'(tx_pkt_count), 64'd0);
`endif

    // Mid-packet reset during beat 5
    clear_metrics();
    stall_done = 1'b1;
    fifo_q.push_back(make_word(1'b0));
    drive_fifo();
    bad = 1;
    for (int i = 0; i < 40 && bad != 0; i++) begin
      step();
      if (m_axis_tvalid && hs_in_pkt == 5) bad = 0;
    end
    check("reach_beat5", 64'(bad), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tdata",  m_axis_tdata,       64'd0);
    check("midrst_tlast",  64'(m_axis_tlast),  64'd0);
    check("midrst_busy",   64'(tx_busy),       64'd0);
    check("midrst_count",  64'(tx_pkt_count), 64'd0);
    sb.delete();
    fifo_q.delete();
    drive_fifo();
    hs_in_pkt = 0;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fifo_pop !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
    end
    check("post_rst_quiet", 64'(bad), 64'd0);

    // Traffic after the reset; the counter restarts from zero
    run_words(2, 0, 0, 1'b0);
`ifdef PKT_TX_STATS_EN
    check("pkt_count_after_rst", 64'(tx_pkt_count), 64'd2);
`else
    check("pkt_count_after_rst", 64'(tx_pkt_count), 64'd0);
`endif
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
